comparator_seq: RTL and testbench
=================================

Name: comparator_seq

Overview:
- Parametrised, multi-cycle magnitude comparator for the RISC-V datapath; successor to the fixed 32-bit combinational comparator.
- Compares operands MSB-chunk-first, one chunk per clock, with early exit on the first differing chunk.
- Supports signed and unsigned modes and uses valid/ready handshakes on both sides.
- Serves branch resolution and SLT/SLTU in the multi-cycle core, where area matters more than latency.

Parameters:
- WIDTH, 32, operand width in bits.
- CHUNK, 4, bits compared per cycle. Must divide WIDTH; elaboration error otherwise.
- NCHUNK, WIDTH/CHUNK, derived (localparam). Chunk index i covers bits [i*CHUNK+CHUNK-1 : i*CHUNK].

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- is_signed  in  1  1 = two's-complement compare, 0 = unsigned.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- eq  out  1  A == B.
- lt  out  1  A < B.
- gt  out  1  A > B.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: state IDLE; in_ready=1; out_valid=0; eq=lt=gt=0; chunk index = NCHUNK-1; operand registers = 0.
- FSM states: IDLE, CMP, DONE.
- IDLE:
  - in_ready=1.
  - Accept occurs on in_valid&in_ready: capture a and b into registers.
  - If is_signed=1, invert bit WIDTH-1 of both captured operands. This offset-binary trick makes signed compare identical to unsigned compare.
  - Load index = NCHUNK-1, then go to CMP.
- CMP:
  - in_ready=0. Each cycle, compare chunk[index] of both registers with the cmp_chunk sub-module.
  - If the chunk shows gt or lt: latch that flag, clear the others, go to DONE.
  - If the chunk is equal and index==0: latch eq=1, go to DONE.
  - Otherwise: decrement index and stay in CMP.
- DONE:
  - out_valid=1; exactly one of eq/lt/gt is 1. Outputs are held stable until out_ready=1.
  - On out_valid&out_ready: clear out_valid and eq/lt/gt on the same edge, go to IDLE.
  - in_ready=0 in DONE, so there is no overlap of result and new request.
- Latency:
  - Let i be the most-significant differing chunk. out_valid rises on the edge at accept+d, where d = NCHUNK-i.
  - If all chunks are equal, d = NCHUNK.
  - Minimum is 1 (MSB chunk differs); maximum is NCHUNK.
- Throughput: one request per d+2 cycles minimum (accept cycle, d compare cycles, handshake cycle).
- Boundary conditions:
  - in_valid while not IDLE: ignored; the inputs are not sampled.
  - a/b/is_signed changing after accept: no effect.
  - out_ready held high in IDLE or CMP: no effect.
  - rst_n low in any state, including mid-CMP or DONE with out_valid high: immediate return to reset values. The pending result is lost; no out_valid pulse.
  - WIDTH==CHUNK (NCHUNK=1): legal, always d=1.
- Outside DONE, eq/lt/gt are 0.

Optional Feature:
- Macro: COMPARATOR_SEQ_FASTEQ_EN.
- Defined:
  - At accept, a full-width equality check a==b runs in parallel with capture.
  - If equal, the FSM goes IDLE→DONE directly with eq=1, so out_valid rises on the accept edge itself (d=0).
  - Unequal operands behave as without the macro.
- Undefined: no full-width XOR tree; equal operands take d=NCHUNK.
- Port list is identical in both builds.

Decomposition:
- Shared package comparator_pkg:
  - cmp_state_t enum {IDLE, CMP, DONE}.
  - cmp_result_t packed struct {eq, lt, gt}.
  - Function for the signed MSB flip.
- One sub-module, cmp_chunk: purely combinational, parameter CHUNK, inputs x and y of width CHUNK, outputs e/g/l.
  - Replaces the fixed 2/4/10-bit comparators for this block.
  - Instantiated once and muxed by index.
- NCHUNK is a localparam in comparator_seq, not in the package.

Test Plan (WIDTH=32, CHUNK=4):
- Unsigned, a=0x8000_0000, b=0x7FFF_FFFF -> gt=1, eq=lt=0, out_valid on accept+1.
- Signed, same operands -> lt=1, gt=eq=0, out_valid on accept+1.
- Unsigned, a=b=0x1234_5678 -> eq=1; out_valid on accept+8, or accept+0 with COMPARATOR_SEQ_FASTEQ_EN.
- Unsigned, a=0x0000_0001, b=0x0000_0002 -> lt=1 on accept+8.
- Signed, a=0xFFFF_FFFF (-1), b=0x0000_0000 -> lt=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid rises -> eq/lt/gt and out_valid stable, in_ready=0, an in_valid pulse with new operands is ignored. out_ready=1 -> in_ready=1 next cycle.
- Reset mid-CMP: rst_n low 2 cycles after accept (a=0x0000_0001, b=0x0000_0002) -> outputs zero immediately, in_ready=1, no out_valid ever for that request.
- Back-to-back: 100 random signed/unsigned pairs with out_ready=1 -> results match a reference model, and each latency equals NCHUNK minus the index of the first differing chunk.

Source files
------------

// File: rtl/comparator_pkg.sv
// comparator_pkg: shared FSM state, result type and signed-offset helper for comparator_seq
package comparator_pkg;
  typedef enum logic [1:0] {IDLE, CMP, DONE} cmp_state_t;
  typedef struct packed {
    logic eq;
    logic lt;
    logic gt;
  } cmp_result_t;
  // Inverting the sign bit maps two's-complement order onto unsigned order
  function automatic logic flip_msb(input logic msb, input logic is_signed);
    return msb ^ is_signed;
  endfunction
endpackage

// File: rtl/cmp_chunk.sv
// cmp_chunk: combinational magnitude compare of one CHUNK-bit slice
module cmp_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  output logic             e,
  output logic             g,
  output logic             l
);
  assign e = x == y;
  assign g = x > y;
  assign l = x < y;
endmodule

// File: rtl/comparator_seq.sv
// comparator_seq: MSB-chunk-first sequential magnitude comparator with early exit
// Optional COMPARATOR_SEQ_FASTEQ_EN: full-width equality at accept skips the chunk walk
module comparator_seq
  import comparator_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             eq,
  output logic             lt,
  output logic             gt
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("comparator_seq: CHUNK must divide WIDTH");
  end
  cmp_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d;
  cmp_result_t      res_q, res_d;
  logic [CHUNK-1:0] ca [NCHUNK];
  logic [CHUNK-1:0] cb [NCHUNK];
  logic             ce, cg, cl;
  for (genvar j = 0; j < NCHUNK; j++) begin : g_chunk
    assign ca[j] = a_q[j*CHUNK +: CHUNK];
    assign cb[j] = b_q[j*CHUNK +: CHUNK];
  end
  cmp_chunk #(.CHUNK(CHUNK)) u_cmp (
    .x(ca[idx_q]),
    .y(cb[idx_q]),
    .e(ce),
    .g(cg),
    .l(cl)
  );
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        a_d            = a;
        b_d            = b;
        a_d[WIDTH-1]   = flip_msb(a[WIDTH-1], is_signed);
        b_d[WIDTH-1]   = flip_msb(b[WIDTH-1], is_signed);
        idx_d          = IW'(NCHUNK - 1);
`ifdef COMPARATOR_SEQ_FASTEQ_EN
        state_d        = (a == b) ? DONE : CMP;
        res_d          = '{eq: a == b, lt: 1'b0, gt: 1'b0};
`else
        state_d        = CMP;
`endif
      end
      CMP: if (!ce) begin
        res_d   = '{eq: 1'b0, lt: cl, gt: cg};
        state_d = DONE;
      end else if (idx_q == '0) begin
        res_d   = '{eq: 1'b1, lt: 1'b0, gt: 1'b0};
        state_d = DONE;
      end else begin
        idx_d = idx_q - 1'b1;
      end
      DONE: if (out_ready) begin
        res_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= IW'(NCHUNK - 1);
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign eq        = res_q.eq;
  assign lt        = res_q.lt;
  assign gt        = res_q.gt;
endmodule

// File: tb/tb_comparator_seq.sv
// tb_comparator_seq: directed and random scoreboard bench for comparator_seq
module tb_comparator_seq;
  localparam int W = 32;
  localparam int C = 4;
  localparam int N = W / C;
  logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, is_signed = 1'b0, out_ready = 1'b0;
  logic         in_ready, out_valid, eq, lt, gt;
  logic [W-1:0] a = '0, b = '0;
  int           checks = 0, failures = 0;
  typedef struct {
    logic [2:0] res;
    int         lat;
    string      tag;
  } exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  comparator_seq #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid),
    .out_ready(out_ready), .eq(eq), .lt(lt), .gt(gt)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  function automatic logic [2:0] ref_res(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    logic l;
    l = s ? ($signed(x) < $signed(y)) : (x < y);
    return {x == y, l, (x != y) && !l};
  endfunction
  function automatic int ref_lat(input logic [W-1:0] x, input logic [W-1:0] y);
    if (x == y) begin
`ifdef COMPARATOR_SEQ_FASTEQ_EN
      return 0;
`else
      return N;
`endif
    end
    for (int i = N - 1; i >= 0; i--)
      if (x[i*C +: C] != y[i*C +: C]) return N - i;
    return N;
  endfunction
  task automatic start_req(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input string tag);
    int t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    a = x; b = y; is_signed = s; in_valid = 1'b1;
    sb.push_back('{ref_res(x, y, s), ref_lat(x, y), tag});
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom(); b = $urandom(); is_signed = ~s;
  endtask
  task automatic finish_req(input int hold);
    int   lat = 0;
    exp_t e;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    e = sb.pop_front();
    check({e.tag, " out_valid"}, 32'(out_valid), 32'd1);
    check({e.tag, " result"}, 32'({eq, lt, gt}), 32'(e.res));
    check({e.tag, " latency"}, 32'(lat), 32'(e.lat));
    check({e.tag, " in_ready busy"}, 32'(in_ready), 32'd0);
    out_ready = 1'b0;
    for (int k = 0; k < hold; k++) begin
      if (k == 2) begin
        in_valid = 1'b1; a = 32'h0; b = 32'h0;
      end else in_valid = 1'b0;
      @(posedge clk); #1;
      check({e.tag, " hold"}, 32'({out_valid, in_ready, eq, lt, gt}), 32'({2'b10, e.res}));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({e.tag, " released"}, 32'({out_valid, eq, lt, gt, in_ready}), 32'b00001);
  endtask
  initial begin
    logic         seen;
    logic [W-1:0] x, y;
    #2;
    check("reset state", 32'({in_ready, out_valid, eq, lt, gt}), 32'b10000);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    start_req(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, "u_msb");    finish_req(0);
    start_req(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, "s_msb");    finish_req(0);
    start_req(32'h1234_5678, 32'h1234_5678, 1'b0, "u_eq");     finish_req(0);
    start_req(32'h0000_0001, 32'h0000_0002, 1'b0, "u_lsb");    finish_req(0);
    start_req(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, "s_neg1");   finish_req(0);
    start_req(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, "u_max");    finish_req(0);
    start_req(32'h0000_0000, 32'h0000_0000, 1'b1, "s_zero");   finish_req(0);
    start_req(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, "bp");       finish_req(5);
    @(posedge clk); #1;
    check("bp no new request", 32'({out_valid, in_ready}), 32'b01);
    out_ready = 1'b1;
    start_req(32'h0000_0001, 32'h0000_0002, 1'b0, "rst");
    @(posedge clk); #1;
    check("rst mid-cmp outputs", 32'({out_valid, eq, lt, gt, in_ready}), 32'b00000);
    rst_n = 1'b0;
    #1;
    check("rst immediate", 32'({out_valid, eq, lt, gt, in_ready}), 32'b00001);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      seen |= out_valid;
    end
    check("rst no out_valid", 32'(seen), 32'd0);
    for (int k = 0; k < 100; k++) begin
      x = $urandom();
      case (k % 4)
        0: y = $urandom();
        1: y = x;
        2: y = x ^ (32'h1 << $urandom_range(0, 31));
        default: y = x ^ (32'hF << (4 * $urandom_range(0, 7)));
      endcase
      out_ready = 1'b1;
      start_req(x, y, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", k));
      finish_req(0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
